outer_product_engine: RTL and testbench

Parametrised vector-product engine for the classifier datapath. It snapshots two signed vectors on a start pulse and runs in one of two modes. In outer-product mode it streams every element a[i]·b[j], row-major. In dot-product mode it produces a single accumulated sum. Every result is quantised back to DW bits with a runtime arithmetic shift, round-half-up and saturation, and delivered over a valid/ready stream. It replaces the fixed 15×16, truncating, array-output product block, and feeds the downstream requantise/softmax stages.

---
 rtl/outer_product_engine.sv | 203 ++++++++++++++++++++
 tb/tb_outer_product_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outer_product_engine.sv
// rtl/outer_product_engine.sv - snapshot vector engine streaming quantised outer-product or dot-product results
module outer_product_engine #(
    parameter  int ROWS  = 15,
    parameter  int COLS  = 16,
    parameter  int DW    = 8,
    localparam int SW    = $clog2(2 * DW),
    localparam int ACC_W = 2 * DW + $clog2(ROWS),
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic [SW-1:0]           shift,
    input  logic [ROWS-1:0][DW-1:0] mat_a,
    input  logic [COLS-1:0][DW-1:0] mat_b,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DW-1:0]    out_data,
    output logic [RW-1:0]           out_row,
    output logic [CW-1:0]           out_col,
    output logic                    out_sat,
    output logic                    done
);
    localparam int IW = $clog2(ROWS + 1);

    if (COLS < ROWS) begin : g_bad_cfg
        $error("outer_product_engine: COLS must be >= ROWS");
    end

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_ACC, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ROWS-1:0][DW-1:0] a_q, a_d;
    logic [COLS-1:0][DW-1:0] b_q, b_d;
    logic [SW-1:0]           shift_q, shift_d;
    logic [IW-1:0]           i_q, i_d;
    logic [CW-1:0]           j_q, j_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    valid_q, valid_d;
    logic                    sat_q, sat_d;
    logic signed [DW-1:0]    data_q, data_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;

    logic                    load, last_beat, acc_end;
    logic [CW-1:0]           b_idx;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W:0]   q_in, q_rnd, q_sh;
    logic [ACC_W-DW+1:0]     q_hi;
    logic                    q_sat;
    logic signed [DW-1:0]    q_data;

    assign load      = !valid_q || out_ready;
    assign last_beat = (i_q == IW'(ROWS - 1)) && (j_q == CW'(COLS - 1));
    assign acc_end   = (i_q == IW'(ROWS));
    // The dot product walks the diagonal, so b shares the row counter there
    assign b_idx     = (state_q == S_ACC) ? CW'(i_q) : j_q;
    assign prod      = $signed(a_q[i_q]) * $signed(b_q[b_idx]);

    // One guard bit above ACC_W keeps the half-up rounding add from wrapping
    always_comb begin
        q_in  = (state_q == S_ACC) ? (ACC_W + 1)'(acc_q) : (ACC_W + 1)'(prod);
        q_rnd = q_in;
        if (shift_q != '0) begin
            q_rnd = q_in + ((ACC_W + 1)'(1) << (shift_q - SW'(1)));
        end
        q_sh  = q_rnd >>> shift_q;
        q_hi  = q_sh[ACC_W:DW-1];
        q_sat = !((&q_hi) || !(|q_hi));
        if (!q_sat) begin
            q_data = q_sh[DW-1:0];
        end else if (q_sh[ACC_W]) begin
            q_data = {1'b1, {(DW - 1){1'b0}}};
        end else begin
            q_data = {1'b0, {(DW - 1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = mode ? S_ACC : S_RUN;
            S_RUN:   if (load && last_beat) state_d = S_DRAIN;
            S_ACC:   if (acc_end) state_d = S_DRAIN;
            S_DRAIN: if (out_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN, S_ACC, S_DRAIN: busy = 1'b1;
            S_DONE:                done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        shift_d = shift_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        sat_d   = sat_q;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = mat_a;
                    b_d     = mat_b;
                    shift_d = shift;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                if (load) begin
                    data_d  = q_data;
                    sat_d   = q_sat;
                    row_d   = RW'(i_q);
                    col_d   = j_q;
                    valid_d = 1'b1;
                    if (j_q == CW'(COLS - 1)) begin
                        j_d = '0;
                        i_d = i_q + IW'(1);
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end
            end
            S_ACC: begin
                if (acc_end) begin
                    data_d  = q_data;
                    sat_d   = q_sat;
                    row_d   = '0;
                    col_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    acc_d = acc_q + ACC_W'(prod);
                    i_d   = i_q + IW'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_outer_product_engine.sv
// tb/tb_outer_product_engine.sv - randomized self-checking bench for outer_product_engine
module tb_outer_product_engine;
    localparam int ROWS = 15;
    localparam int COLS = 16;
    localparam int DW   = 8;
    localparam int SW   = $clog2(2 * DW);
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    mode = 1'b0;
    logic                    out_ready = 1'b0;
    logic [SW-1:0]           shift = '0;
    logic [ROWS-1:0][DW-1:0] mat_a = '0;
    logic [COLS-1:0][DW-1:0] mat_b = '0;
    logic                    busy, out_valid, out_sat, done;
    logic signed [DW-1:0]    out_data;
    logic [RW-1:0]           out_row;
    logic [CW-1:0]           out_col;

    typedef struct {
        int d;
        int r;
        int c;
        int s;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    va[ROWS];
    int    vb[COLS];
    beat_t got[$];
    beat_t expq[$];
    int    first_c, done_c, stalls;

    outer_product_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .shift(shift),
        .mat_a(mat_a), .mat_b(mat_b), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .out_sat(out_sat), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic beat_t quant_model(input longint x, input int sh, input int r, input int c);
        beat_t  b;
        longint y  = x;
        longint mx = (longint'(1) << (DW - 1)) - 1;
        longint mn = -(longint'(1) << (DW - 1));
        if (sh > 0) y = y + (longint'(1) << (sh - 1));
        y = y >>> sh;
        b.r = r;
        b.c = c;
        if (y > mx) begin
            b.d = int'(mx); b.s = 1;
        end else if (y < mn) begin
            b.d = int'(mn); b.s = 1;
        end else begin
            b.d = int'(y); b.s = 0;
        end
        return b;
    endfunction

    task automatic build_model(input bit md, input int sh);
        longint sum = 0;
        expq.delete();
        if (!md) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    expq.push_back(quant_model(longint'(va[i] * vb[j]), sh, i, j));
        end else begin
            for (int k = 0; k < ROWS; k++) sum += longint'(va[k] * vb[k]);
            expq.push_back(quant_model(sum, sh, 0, 0));
        end
    endtask

    function automatic beat_t capture();
        beat_t b;
        b.d = int'(out_data);
        b.r = int'(out_row);
        b.c = int'(out_col);
        b.s = int'(out_sat);
        return b;
    endfunction

    task automatic rand_vecs();
        for (int i = 0; i < ROWS; i++) va[i] = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
        for (int j = 0; j < COLS; j++) vb[j] = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
    endtask

    task automatic drive_vecs();
        for (int i = 0; i < ROWS; i++) mat_a[i] = DW'(va[i]);
        for (int j = 0; j < COLS; j++) mat_b[j] = DW'(vb[j]);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic run_op(input bit md, input int sh, input bit rnd, input bit spur);
        beat_t hb;
        bit    hold = 0;
        build_model(md, sh);
        got.delete();
        first_c = -1;
        done_c  = -1;
        stalls  = 0;
        drive_vecs();
        mode  = md;
        shift = SW'(sh);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        mode  = ~md;
        shift = SW'($urandom);
        for (int i = 0; i < ROWS; i++) mat_a[i] = DW'($urandom);
        for (int j = 0; j < COLS; j++) mat_b[j] = DW'($urandom);
        for (int c = 0; c < 4000; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (spur && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (done) begin
                done_c = c;
                break;
            end
            if (hold) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hb.d);
                chk("stall_row", out_row, hb.r);
                chk("stall_col", out_col, hb.c);
                chk("stall_sat", out_sat, hb.s);
            end
            hold = 0;
            if (out_valid) begin
                if (first_c < 0) first_c = c;
                if (out_ready) begin
                    got.push_back(capture());
                end else begin
                    hold = 1;
                    hb   = capture();
                    stalls++;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", done_c >= 0, 1);
        if (done_c >= 0) begin
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
        end
        chk("beat_count", got.size(), expq.size());
        for (int k = 0; k < got.size() && k < expq.size(); k++) begin
            chk("beat_data", got[k].d, expq[k].d);
            chk("beat_row", got[k].r, expq[k].r);
            chk("beat_col", got[k].c, expq[k].c);
            chk("beat_sat", got[k].s, expq[k].s);
        end
    endtask

    task automatic directed_vecs();
        for (int i = 0; i < ROWS; i++) va[i] = i - 7;
        for (int j = 0; j < COLS; j++) vb[j] = j - 8;
    endtask

    int qa[5]  = '{-128, -128, -128, 3, -3};
    int qb[5]  = '{-128, -128, -128, 5, 5};
    int qs[5]  = '{0, 7, 8, 1, 1};
    int qd[5]  = '{127, 127, 64, 8, -7};
    int qst[5] = '{1, 1, 0, 0, 0};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        directed_vecs();
        run_op(1'b0, 0, 1'b0, 1'b0);
        chk("outer_first_valid", first_c, 1);
        chk("outer_done_cycle", done_c, ROWS * COLS + 1);
        if (got.size() == ROWS * COLS) begin
            chk("beat_0_0", got[0].d, 56);
            chk("beat_0_15", got[15].d, -49);
            chk("beat_14_15", got[ROWS * COLS - 1].d, 49);
            chk("last_row", got[ROWS * COLS - 1].r, 14);
            chk("last_col", got[ROWS * COLS - 1].c, 15);
        end

        for (int t = 0; t < 5; t++) begin
            rand_vecs();
            va[0] = qa[t];
            vb[0] = qb[t];
            run_op(1'b0, qs[t], 1'b0, 1'b0);
            if (got.size() > 0) begin
                chk("quant_data", got[0].d, qd[t]);
                chk("quant_sat", got[0].s, qst[t]);
            end
        end

        for (int i = 0; i < ROWS; i++) va[i] = 1;
        for (int j = 0; j < COLS; j++) vb[j] = 2;
        run_op(1'b1, 0, 1'b0, 1'b0);
        chk("dot_first_valid", first_c, ROWS + 1);
        chk("dot_done_cycle", done_c, ROWS + 2);
        if (got.size() > 0) begin
            chk("dot_sum", got[0].d, 30);
            chk("dot_row", got[0].r, 0);
            chk("dot_col", got[0].c, 0);
        end

        for (int i = 0; i < ROWS; i++) va[i] = 127;
        for (int j = 0; j < COLS; j++) vb[j] = 127;
        run_op(1'b1, 4, 1'b0, 1'b0);
        if (got.size() > 0) begin
            chk("dot_sat_data", got[0].d, 127);
            chk("dot_sat_flag", got[0].s, 1);
        end

        directed_vecs();
        run_op(1'b0, 0, 1'b1, 1'b1);
        chk("bp_outer_cycles", done_c, ROWS * COLS + 1 + stalls);
        run_op(1'b1, 3, 1'b1, 1'b1);
        chk("bp_dot_cycles", done_c, ROWS + 2 + stalls);

        for (int t = 0; t < 6; t++) begin
            bit md;
            int sh;
            rand_vecs();
            md = 1'($urandom_range(0, 1));
            sh = int'($urandom_range(0, 2 * DW - 1));
            run_op(md, sh, 1'b1, 1'b1);
            chk("rand_cycles", done_c, (md ? ROWS + 2 : ROWS * COLS + 1) + stalls);
        end

        directed_vecs();
        drive_vecs();
        mode  = 1'b0;
        shift = '0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (38) @(negedge clk);
        chk("abort_at_beat37_valid", out_valid, 1);
        chk("abort_at_beat37_row", out_row, 2);
        chk("abort_at_beat37_col", out_col, 5);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_sat", out_sat, 0);
        chk("abort_done", done, 0);
        chk("abort_data", out_data, 0);
        chk("abort_row", out_row, 0);
        chk("abort_col", out_col, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 0, 1'b0, 1'b0);
        chk("restart_done_cycle", done_c, ROWS * COLS + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
